axis_dest_demux: RTL and testbench

- Single-input, M_COUNT-output AXI-Stream router; the fan-out counterpart of the many-to-one stream switch.
- Decodes tdest on the first beat of each frame against per-output address ranges, then locks the route for the whole frame.
- Frames whose tdest matches no range are consumed and dropped.
- Every output has one registered pipeline stage.

---
 rtl/axis_demux_pkg.sv | 33 +++
 rtl/axis_out_reg.sv | 50 +++++
 rtl/axis_dest_demux.sv | 147 ++++++++++++++
 tb/tb_axis_dest_demux.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_demux_pkg.sv
// Shared definitions for the tdest-routed AXI-Stream demultiplexer.
//   state_e    : router FSM encoding (IDLE=0, ROUTE=1, DROP=2)
//   range_hit  : inclusive unsigned base/top compare for one output range
//   lowest_hit : index of the lowest set bit of a hit vector (0 if none)
package axis_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  // Hit vectors are carried at this fixed width so the helpers stay generic.
  localparam int unsigned DEC_MAX = 32;

  // Operands are zero-extended from DEST_WIDTH, so the compare stays unsigned.
  function automatic logic range_hit(input logic [DEC_MAX-1:0] dest,
                                     input logic [DEC_MAX-1:0] base,
                                     input logic [DEC_MAX-1:0] top);
    return (dest >= base) && (dest <= top);
  endfunction

  // The scan runs from high to low, so the lowest matching index is written last and wins.
  function automatic logic [4:0] lowest_hit(input logic [DEC_MAX-1:0] hits);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = DEC_MAX - 1; i >= 0; i--) begin
      if (hits[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready register slice for one demux output.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : upstream handshake targeting this slot (capture data_i)
//   data_i      : packed beat {data, keep, last, id, dest, user}
//   m_ready_i   : downstream ready
//   m_valid_o   : downstream valid
//   m_data_o    : held beat
//   ready_o     : slot can take a beat this cycle (empty or draining)
module axis_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             ready_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (m_ready_i) valid_d = 1'b0;
    // A load in the same cycle as an unload keeps the slot full with the new beat.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign ready_o   = m_ready_i | ~valid_q;

endmodule

// File: rtl/axis_dest_demux.sv
// One-to-M_COUNT AXI-Stream router. The router decodes tdest on the first beat of a
// frame against per-output [base, top] ranges and keeps that route until tlast.
// Frames with an unmatched tdest are consumed and dropped, and stat_drop pulses once
// for each dropped frame.
//   s_axis_*     : single slave input stream
//   m_axis_*     : M_COUNT master outputs, slice i belongs to output i
//   stat_drop    : one-cycle pulse after the tlast beat of a dropped frame is accepted
module axis_dest_demux
  import axis_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 3,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_BASE = {3'd6, 3'd4, 3'd2, 3'd0},
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_TOP  = {3'd6, 3'd5, 3'd3, 3'd1}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]   m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0] m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  output logic                          stat_drop
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int PW    = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   stat_drop_q, stat_drop_d;

  logic [DEC_MAX-1:0]     hits;
  logic [4:0]             hit_idx;
  logic [M_COUNT-1:0]     load;
  logic [M_COUNT-1:0]     slot_ready;
  logic                   s_ready;
  logic [ID_WIDTH-1:0]    id_in;
  logic [USER_WIDTH-1:0]  user_in;
  logic [PW-1:0]          s_beat;
  logic [M_COUNT*PW-1:0]  m_beat;

  always_comb begin
    hits = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      hits[i] = range_hit(DEC_MAX'(s_axis_tdest),
                          DEC_MAX'(M_BASE[i*DEST_WIDTH +: DEST_WIDTH]),
                          DEC_MAX'(M_TOP[i*DEST_WIDTH +: DEST_WIDTH]));
    end
    hit_idx = lowest_hit(hits);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    stat_drop_d = 1'b0;
    s_ready     = 1'b0;
    load        = '0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          if (hits != '0) begin
            sel_d   = SEL_W'(hit_idx);
            state_d = ST_ROUTE;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_ROUTE: begin
        s_ready = slot_ready[sel_q];
        if (s_axis_tvalid && s_ready) begin
          load[sel_q] = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          stat_drop_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      stat_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign stat_drop     = stat_drop_q;

  // Disabled sidebands are stored as zero, so their outputs read 0 even after a load.
  assign id_in   = ID_ENABLE   ? s_axis_tid   : {ID_WIDTH{1'b0}};
  assign user_in = USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}};
  assign s_beat  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, id_in, s_axis_tdest, user_in};

  for (genvar g = 0; g < M_COUNT; g++) begin : g_out
    logic [KEEP_WIDTH-1:0] keep_r;

    axis_out_reg #(.WIDTH(PW)) u_out (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load[g]),
      .data_i    (s_beat),
      .m_ready_i (m_axis_tready[g]),
      .m_valid_o (m_axis_tvalid[g]),
      .m_data_o  (m_beat[g*PW +: PW]),
      .ready_o   (slot_ready[g])
    );

    assign {m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH], keep_r, m_axis_tlast[g],
            m_axis_tid[g*ID_WIDTH +: ID_WIDTH], m_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH],
            m_axis_tuser[g*USER_WIDTH +: USER_WIDTH]} = m_beat[g*PW +: PW];

    assign m_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] = KEEP_ENABLE ? keep_r : {KEEP_WIDTH{1'b1}};
  end

endmodule

// File: tb/tb_axis_dest_demux.sv
module tb_axis_dest_demux;

  localparam int M   = 4;
  localparam int DW  = 16;
  localparam int KW  = 2;
  localparam int IW  = 8;
  localparam int DSW = 3;
  localparam int UW  = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_axis_tdata;
  logic [KW-1:0]   s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [IW-1:0]   s_axis_tid;
  logic [DSW-1:0]  s_axis_tdest;
  logic [UW-1:0]   s_axis_tuser;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M*KW-1:0] m_axis_tkeep;
  logic [M-1:0]    m_axis_tvalid;
  logic [M-1:0]    m_axis_tready;
  logic [M-1:0]    m_axis_tlast;
  logic [M*IW-1:0] m_axis_tid;
  logic [M*DSW-1:0] m_axis_tdest;
  logic [M*UW-1:0] m_axis_tuser;
  logic            stat_drop;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int drop_cnt = 0;
  logic [M-1:0] seen = '0;
  int first_cyc [M];
  logic [31:0] obs_q [M][$];

  axis_dest_demux #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .stat_drop     (stat_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [15:0] d, input logic [1:0] k, input logic l,
                                     input logic [7:0] id, input logic [2:0] de, input logic u);
    return {1'b0, d, k, l, id, de, u};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < M; i++) begin
        if (m_axis_tvalid[i]) begin
          if (!seen[i]) begin
            seen[i] = 1'b1;
            first_cyc[i] = cyc;
          end
          if (m_axis_tready[i])
            obs_q[i].push_back(pk(m_axis_tdata[i*DW +: DW], m_axis_tkeep[i*KW +: KW],
                                  m_axis_tlast[i], m_axis_tid[i*IW +: IW],
                                  m_axis_tdest[i*DSW +: DSW], m_axis_tuser[i]));
        end
      end
      if (stat_drop) drop_cnt = drop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic send_beat(input logic [2:0] dest, input logic [15:0] data, input logic [1:0] keep,
                           input logic last, input logic [7:0] id, input logic u, output int ncyc);
    logic hs;
    logic done;
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = dest;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tid    = id;
    s_axis_tuser  = u;
    ncyc = 0;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      ncyc++;
      if (hs) done = 1'b1;
    end
    if (!done) chk("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [2:0] dest, input int n, input logic [15:0] d0,
                            input logic [1:0] keep, input logic [7:0] id, input logic u,
                            output int total);
    int c;
    total = 0;
    for (int k = 0; k < n; k++) begin
      send_beat(dest, d0 + 16'(k), keep, (k == n - 1), id, u, c);
      total += c;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int t0;
    int d0;
    int base [M];

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = '0;
    s_axis_tdest  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 4'hF;
    #12;
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_drop",   32'(stat_drop), 32'd0);
    chk("rst_tdata",  m_axis_tdata[31:0], 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four-beat frame to output 1.
    t0 = cyc;
    send_frame(3'd3, 4, 16'h00A0, 2'b11, 8'h11, 1'b0, c);
    chk("t1_cycles", 32'(c), 32'd5);
    drain();
    chk("t1_latency", 32'(first_cyc[1] - t0), 32'd2);
    chk("t1_q1_size", 32'(obs_q[1].size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_q[1].size(); k++)
      chk("t1_beat", obs_q[1][k], pk(16'h00A0 + 16'(k), 2'b11, (k == 3), 8'h11, 3'd3, 1'b0));
    chk("t1_q0_size", 32'(obs_q[0].size()), 32'd0);
    chk("t1_q2_size", 32'(obs_q[2].size()), 32'd0);
    chk("t1_q3_size", 32'(obs_q[3].size()), 32'd0);

    // Unmatched tdest: consumed and dropped.
    for (int i = 0; i < M; i++) base[i] = obs_q[i].size();
    d0 = drop_cnt;
    send_frame(3'd7, 3, 16'h0070, 2'b11, 8'h22, 1'b0, c);
    chk("t2_cycles", 32'(c), 32'd4);
    chk("t2_drop_pulse", 32'(stat_drop), 32'd1);
    chk("t2_mvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_drop_clear", 32'(stat_drop), 32'd0);
    chk("t2_drop_cnt", 32'(drop_cnt - d0), 32'd1);
    drain();
    for (int i = 0; i < M; i++)
      chk("t2_no_out", 32'(obs_q[i].size() - base[i]), 32'd0);

    // Back-to-back single-beat frames to every output.
    for (int i = 0; i < M; i++) base[i] = obs_q[i].size();
    for (int j = 0; j < M; j++) begin
      send_frame(3'(2 * j), 1, 16'h0010 + 16'(j), 2'b11, 8'h33, 1'b0, c);
      chk("t3_cycles", 32'(c), 32'd2);
    end
    drain();
    for (int i = 0; i < M; i++) begin
      chk("t3_size", 32'(obs_q[i].size() - base[i]), 32'd1);
      if (obs_q[i].size() > base[i])
        chk("t3_beat", obs_q[i][base[i]], pk(16'h0010 + 16'(i), 2'b11, 1'b1, 8'h33, 3'(2 * i), 1'b0));
    end

    // Backpressure on output 2 after its first beat.
    for (int i = 0; i < M; i++) base[i] = obs_q[i].size();
    fork
      send_frame(3'd5, 4, 16'h0050, 2'b11, 8'h44, 1'b1, c);
      begin
        logic found;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
          @(posedge clk);
          #1;
          if (m_axis_tvalid[2]) found = 1'b1;
        end
        chk("t4_valid_seen", 32'(found), 32'd1);
        m_axis_tready[2] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk("t4_hold_data",  32'(m_axis_tdata[47:32]), 32'h0050);
          chk("t4_hold_valid", 32'(m_axis_tvalid[2]), 32'd1);
          chk("t4_s_stall",    32'(s_axis_tready), 32'd0);
          @(posedge clk);
        end
        #1;
        m_axis_tready[2] = 1'b1;
      end
    join
    drain();
    chk("t4_size", 32'(obs_q[2].size() - base[2]), 32'd4);
    for (int k = 0; k < 4 && base[2] + k < obs_q[2].size(); k++)
      chk("t4_beat", obs_q[2][base[2] + k], pk(16'h0050 + 16'(k), 2'b11, (k == 3), 8'h44, 3'd5, 1'b1));

    // Reset in the middle of a frame to output 0, then a new frame to output 2.
    for (int i = 0; i < M; i++) base[i] = obs_q[i].size();
    send_beat(3'd0, 16'h00C0, 2'b11, 1'b0, 8'h55, 1'b0, c);
    send_beat(3'd0, 16'h00C1, 2'b11, 1'b0, 8'h55, 1'b0, c);
    s_axis_tdata = 16'h00C2;
    #2;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk("t5_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t5_rst_tready", 32'(s_axis_tready), 32'd0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(3'd4, 1, 16'h00D0, 2'b11, 8'h66, 1'b0, c);
    chk("t5_new_cycles", 32'(c), 32'd2);
    drain();
    chk("t5_q0_size", 32'(obs_q[0].size() - base[0]), 32'd1);
    if (obs_q[0].size() > base[0])
      chk("t5_q0_beat", obs_q[0][base[0]], pk(16'h00C0, 2'b11, 1'b0, 8'h55, 3'd0, 1'b0));
    chk("t5_q2_size", 32'(obs_q[2].size() - base[2]), 32'd1);
    if (obs_q[2].size() > base[2])
      chk("t5_q2_beat", obs_q[2][base[2]], pk(16'h00D0, 2'b11, 1'b1, 8'h66, 3'd4, 1'b0));

    // Sideband fields forwarded bit-exactly.
    send_frame(3'd2, 1, 16'hBEEF, 2'b01, 8'h5A, 1'b1, c);
    chk("t6_valid", 32'(m_axis_tvalid), 32'b0010);
    chk("t6_tdata", 32'(m_axis_tdata[31:16]), 32'hBEEF);
    chk("t6_tkeep", 32'(m_axis_tkeep[3:2]), 32'b01);
    chk("t6_tid",   32'(m_axis_tid[15:8]), 32'h5A);
    chk("t6_tuser", 32'(m_axis_tuser[1]), 32'd1);
    chk("t6_tdest", 32'(m_axis_tdest[5:3]), 32'd2);
    chk("t6_tlast", 32'(m_axis_tlast[1]), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
